// File: rtl/pipeline_stall_controller_pkg.sv
// Shared pipeline types for the ARM 5-stage core.
// Holds the stall sequencer state encoding and default timeout.
package arm_pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } stall_state_t;

    localparam int DEF_MEM_TIMEOUT = 64;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the stall/bubble debug counters.
// Holds at all-ones once reached.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Freeze/flush sequencer: merges hazard, branch and SRAM handshake
// into per-register freeze and flush enables with a MEM timeout.
module pipeline_stall_controller
    import arm_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             mem_start,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             freeze_id_exe,
    output logic             freeze_exe_mem,
    output logic             freeze_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_exe,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    stall_state_t      state, next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              frz_all;
    logic              frz_front;
    logic              run_rules;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == RUN && mem_req) begin
            wait_cnt <= '0;
        end else if (state == MEM_WAIT && !mem_ready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_error <= 1'b0;
        end else if (next_state == ERROR) begin
            mem_error <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            RUN: begin
                if (mem_req) next_state = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    next_state = RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    next_state = ERROR;
                end
            end
            ERROR: next_state = ERROR;
            default: next_state = RUN;
        endcase
    end

    // Branch outranks hazard: a stalled ID instruction is wrong-path anyway.
    always_comb begin
        mem_start    = 1'b0;
        frz_all      = 1'b0;
        frz_front    = 1'b0;
        run_rules    = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_exe = 1'b0;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (mem_req) begin
                        mem_start = 1'b1;
                        frz_all   = 1'b1;
                    end else begin
                        run_rules = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) run_rules = 1'b1;
                    else           frz_all   = 1'b1;
                end
                ERROR:   frz_all = 1'b1;
                default: frz_all = 1'b0;
            endcase
            if (run_rules) begin
                if (branch_taken) begin
                    flush_if_id  = 1'b1;
                    flush_id_exe = 1'b1;
                end else if (hazard_detected) begin
                    frz_front    = 1'b1;
                    flush_id_exe = 1'b1;
                end
            end
        end
    end

    assign freeze_pc      = frz_all | frz_front;
    assign freeze_if_id   = frz_all | frz_front;
    assign freeze_id_exe  = frz_all;
    assign freeze_exe_mem = frz_all;
    assign freeze_mem_wb  = frz_all;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze_pc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_id_exe),
        .count (bubble_count)
    );

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central freeze/flush sequencer for the 5-stage ARM pipeline. It merges the hazard detector's `hazard_detected`, the EXE-stage branch decision, and the multi-cycle SRAM handshake from the MEM stage into per-register freeze and flush enables. Memory stalls are tracked with a small state machine that includes a timeout. Saturating stall and bubble counters are exposed for debug.

## Interface
- `MEM_TIMEOUT`, 64: maximum MEM_WAIT cycles without `mem_ready` before the controller enters ERROR.
- `CNT_W`, 16: width of the performance counters.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `hazard_detected`  in  1  from the hazard detection unit; the ID instruction must wait.
- `branch_taken`  in  1  from the EXE stage; the IF and ID contents are wrong-path.
- `mem_req`  in  1  MEM-stage instruction is a load or store (`mem_r_en | mem_w_en`).
- `mem_ready`  in  1  from the SRAM controller; the access completes this cycle.
- `mem_start`  out  1  one-cycle pulse that launches the SRAM access.
- `freeze_pc`, `freeze_if_id`, `freeze_id_exe`, `freeze_exe_mem`, `freeze_mem_wb`  out  1 each  hold the corresponding register.
- `flush_if_id`, `flush_id_exe`  out  1 each  load a NOP/bubble into the register.
- `mem_error`  out  1  sticky timeout flag.
- `stall_cycles`, `bubble_count`  out  `CNT_W` each  saturating counters.

## Operation
- States: RUN, MEM_WAIT, ERROR. Reset enters RUN.
- **RUN with `mem_req`=1:**
  - assert `mem_start`;
  - assert all five freezes; flushes are 0;
  - next state MEM_WAIT; `wait_cnt` is cleared.
- **RUN with `mem_req`=0 and `branch_taken`=1:** `flush_if_id`=1 and `flush_id_exe`=1, with no freezes. Branch beats hazard, because the ID instruction is wrong-path.
- **RUN with `mem_req`=0, `branch_taken`=0 and `hazard_detected`=1:** `freeze_pc`=1, `freeze_if_id`=1 and `flush_id_exe`=1, which inserts a bubble.
- **RUN otherwise:** all outputs 0.
- **MEM_WAIT:**
  - All five freezes are asserted every cycle except a cycle with `mem_ready`=1.
  - In a `mem_ready`=1 cycle, freezes drop and RUN's branch/hazard rules apply to the current inputs. The next state is RUN.
  - `branch_taken` and `hazard_detected` are ignored while frozen. EXE is held, so the branch is re-evaluated on release.
- **Timeout:**
  - `wait_cnt` increments on each MEM_WAIT cycle with `mem_ready`=0.
  - When `wait_cnt` == `MEM_TIMEOUT`-1 and `mem_ready`=0, the next state is ERROR.
- **ERROR:** all freezes are 1, `mem_error`=1, and `mem_ready` is ignored. Only `rst` exits this state.
- `mem_ready` in RUN or ERROR is ignored, because SRAM completes no earlier than the cycle after `mem_start`.
- **Counters:**
  - `stall_cycles` +1 every cycle in which `freeze_pc`=1.
  - `bubble_count` +1 every cycle in which `flush_id_exe`=1.
  - Both saturate at all-ones.

## Timing
- Freeze and flush outputs are combinational (Mealy) from the state and current inputs. They are valid in the same cycle, before the pipeline edge.
- `mem_start` is high for exactly one cycle per access: the RUN cycle in which `mem_req` is seen.
- Minimum memory stall is 2 cycles: the RUN/start cycle plus one MEM_WAIT cycle with ready.
- Back-to-back memory instructions: after the ready cycle the state is RUN. If the next MEM instruction has `mem_req`=1, `mem_start` is issued in that RUN cycle, so there is no dead cycle.
- Reset values: state=RUN, `wait_cnt`=0, `mem_error`=0, both counters=0. All combinational outputs evaluate to 0 under `rst`.
- Reset asserted mid-MEM_WAIT or in ERROR returns to RUN on the next edge. No `mem_start` is issued in the reset cycle.

## Structure
- Shared package `arm_pipe_pkg` holds:
  - the state enum `stall_state_t` (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2);
  - the default `MEM_TIMEOUT`.
- One sub-module, `sat_counter`, is parameterised by width with `clk`, `rst` and `inc` inputs. It is instantiated twice, once per counter.

## Test plan
- Reset, then idle for 5 cycles -> all outputs 0, counters 0, `mem_error`=0.
- `hazard_detected`=1 for 1 cycle in RUN -> `freeze_pc`, `freeze_if_id` and `flush_id_exe` are high for 1 cycle; `bubble_count`=1, `stall_cycles`=1.
- `branch_taken`=1 and `hazard_detected`=1 in the same cycle -> both flushes=1, `freeze_pc`=0; `bubble_count`=1, `stall_cycles`=0.
- `mem_req`=1 with `mem_ready` arriving 3 cycles later -> `mem_start` pulses once; freezes high for 3 cycles and low in the ready cycle; `stall_cycles`=3. `branch_taken` held high during the stall -> flushes appear only in the ready cycle.
- `MEM_TIMEOUT`=4 and `mem_ready` never asserted -> ERROR after 4 MEM_WAIT cycles; `mem_error` stays 1 and freezes stay 1 even when `mem_ready` pulses. `rst` -> RUN with `mem_error`=0.
- Force `stall_cycles` to 2^`CNT_W`-2 via a long stall -> it reaches all-ones and holds.
